// File: rtl/boot_load_ctrl_if.sv
// Byte-link and imem write-port bundle for boot_load_ctrl.
// master = controller side, slave = link source / imem side.
interface boot_load_ctrl_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/boot_load_ctrl.sv
// Boot loader: holds the core in reset, streams a LE length-prefixed image into imem, then releases it.
// Build macro BOOT_CHECKSUM_EN adds a trailing 8-bit payload checksum byte and the CHECK state.
module boot_load_ctrl #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  boot_load_ctrl_if.master bus,
  output logic             core_reset,
  output logic             done,
  output logic             error
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE_W     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, LEN, LOAD, RUN, ERR
`ifdef BOOT_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [23:0]           acc_q, acc_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [CW-1:0]         widx_q, widx_d;
  logic [CW-1:0]         nwords_q, nwords_d;
  logic                  settle_q, settle_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        fire;
  logic [31:0] word;

  // acc_q holds the previous three bytes; word is the full LE word on the 4th byte
  assign fire = bus.rx_valid & rx_ready_q;
  assign word = {bus.rx_data, acc_q};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    bcnt_d   = bcnt_q;
    widx_d   = widx_q;
    nwords_d = nwords_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d  = LEN;
          acc_d    = '0;
          bcnt_d   = '0;
          widx_d   = '0;
          nwords_d = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d    = '0;
`endif
        end
      end
      LEN: begin
        if (fire) begin
          acc_d  = word[31:8];
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if ((word[31:CW] != '0) || (word[CW-1:0] == '0) || (word[CW-1:0] > MAX_WORDS)) begin
              state_d = ERR;
            end else begin
              state_d  = LOAD;
              nwords_d = word[CW-1:0];
            end
          end
        end
      end
      LOAD: begin
        if (fire) begin
          acc_d  = word[31:8];
          bcnt_d = bcnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          sum_d  = sum_q + bus.rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_WIDTH-1:0];
            wdata_d = word;
            widx_d  = widx_q + ONE_W;
            if (widx_q == nwords_q - ONE_W) begin
`ifdef BOOT_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = RUN;
`endif
            end
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: begin
        if (fire) state_d = (bus.rx_data == sum_q) ? RUN : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == LEN) || (state_d == LOAD);
`ifdef BOOT_CHECKSUM_EN
    if (state_d == CHECK) rx_ready_d = 1'b1;
`endif
    done_d  = (state_d == RUN);
    error_d = (state_d == ERR);
    // core leaves reset only on the second consecutive RUN cycle, after the last imem write commits
    settle_d     = (state_q == RUN) && (state_d == RUN);
    core_reset_d = !(settle_d && settle_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      bcnt_q       <= '0;
      widx_q       <= '0;
      nwords_q     <= '0;
      settle_q     <= 1'b0;
      rx_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bcnt_q       <= bcnt_d;
      widx_q       <= widx_d;
      nwords_q     <= nwords_d;
      settle_q     <= settle_d;
      rx_ready_q   <= rx_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_reset     = core_reset_q;
  assign done           = done_q;
  assign error          = error_q;
endmodule

// File: tb/tb_boot_load_ctrl.sv
// Bench for boot_load_ctrl: byte-stream reference model checked every cycle, plus literal spot checks.
// Honours BOOT_CHECKSUM_EN the same way as the design.
module tb_boot_load_ctrl;
  localparam int AW   = 6;
  localparam int MAXW = 1 << AW;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic core_reset, done, error;

  boot_load_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  boot_load_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: interprets the accepted byte stream by byte count.
  logic [7:0]    mq[$];
  logic          m_busy = 1'b0, m_ready = 1'b0, m_we = 1'b0;
  logic          m_done = 1'b0, m_err = 1'b0, m_cr = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic [31:0]   m_len = '0;
  int            m_rel = 0;

  function automatic logic [31:0] qword(input int base);
    return {mq[base+3], mq[base+2], mq[base+1], mq[base]};
  endfunction

  function automatic logic [7:0] mq_payload_sum(input int last);
    logic [7:0] s = 8'h00;
    for (int i = 4; i < last; i++) s = s + mq[i];
    return s;
  endfunction

  task automatic m_finish(input bit ok);
    m_busy  = 1'b0;
    m_ready = 1'b0;
    if (ok) begin m_done = 1'b1; m_rel = 2; end
    else    m_err = 1'b1;
  endtask

  task automatic model_step();
    int n;
    m_we = 1'b0;
    if (m_rel > 0) begin
      m_rel--;
      if (m_rel == 0) m_cr = 1'b0;
    end
    if (!m_busy) begin
      if (start) begin
        mq.delete();
        m_busy = 1'b1; m_ready = 1'b1; m_done = 1'b0; m_err = 1'b0; m_cr = 1'b1; m_rel = 0;
      end
    end else if (bus.rx_valid) begin
      mq.push_back(bus.rx_data);
      n = mq.size();
      if (n == 4) begin
        m_len = qword(0);
        if (m_len == 0 || m_len > MAXW) m_finish(1'b0);
      end else if (n > 4 && n % 4 == 0 && n <= 4 + 4 * int'(m_len)) begin
        m_we    = 1'b1;
        m_addr  = AW'((n - 8) / 4);
        m_wdata = qword(n - 4);
        if (!CHK && n == 4 + 4 * int'(m_len)) m_finish(1'b1);
      end else if (CHK && n == 5 + 4 * int'(m_len)) begin
        m_finish(mq[n-1] == mq_payload_sum(n - 1));
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      m_busy = 1'b0; m_ready = 1'b0; m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_cr = 1'b1; m_addr = '0; m_wdata = '0; m_len = '0; m_rel = 0;
    end else begin
      model_step();
    end
  end

  // Write log captured from the DUT for literal checks after each load
  logic [31:0] dmem [0:MAXW-1];
  int          nwr = 0;
  int          last_addr = -1;

  initial begin
    @(negedge reset);
    forever begin
      @(negedge clk);
      check("rx_ready",   32'(bus.rx_ready),  32'(m_ready));
      check("imem_we",    32'(bus.imem_we),   32'(m_we));
      check("imem_addr",  32'(bus.imem_addr), 32'(m_addr));
      check("imem_wdata", bus.imem_wdata,     m_wdata);
      check("done",       32'(done),          32'(m_done));
      check("error",      32'(error),         32'(m_err));
      check("core_reset", 32'(core_reset),    32'(m_cr));
      if (bus.imem_we === 1'b1) begin
        dmem[bus.imem_addr] = bus.imem_wdata;
        nwr++;
        last_addr = int'(bus.imem_addr);
      end
    end
  end

  logic [7:0] img[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_b(input logic [7:0] b);
    img.push_back(b);
  endtask

  task automatic put_w(input logic [31:0] w);
    for (int k = 0; k < 4; k++) img.push_back(w[8*k +: 8]);
  endtask

  function automatic logic [7:0] img_sum();
    logic [7:0] s = 8'h00;
    for (int i = 4; i < img.size(); i++) s = s + img[i];
    return s;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_img(input int gapmax, input int start_at);
    for (int i = 0; i < img.size(); i++) begin
      if (gapmax > 0) begin
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(gapmax, 0)) tick();
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = img[i];
      if (i == start_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    bus.rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] wpat(input int i);
    return 32'(i) * 32'h01030507 + 32'h0BADF00D;
  endfunction

  logic [31:0] ref_words [0:7];
  logic [31:0] copy_words [0:7];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst core_reset", 32'(core_reset),   32'd1);
    check("rst rx_ready",   32'(bus.rx_ready), 32'd0);
    check("rst imem_addr",  32'(bus.imem_addr), 32'd0);
    check("rst done",       32'(done),         32'd0);

    // Reset mid-LOAD after six bytes
    img.delete(); put_w(32'd2); put_b(8'h13); put_b(8'h00);
    tick();
    pulse_start();
    send_img(0, -1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst core_reset", 32'(core_reset),   32'd1);
    check("midrst rx_ready",   32'(bus.rx_ready), 32'd0);
    check("midrst imem_we",    32'(bus.imem_we),  32'd0);
    check("midrst done",       32'(done),         32'd0);
    check("midrst error",      32'(error),        32'd0);
    tick();
    reset = 1'b1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
    repeat (2) tick();
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("idle rx_ready", 32'(bus.rx_ready), 32'd0);

    // Two-word image
    img.delete(); put_w(32'd2); put_w(32'h00000013); put_w(32'h00500093);
    if (CHK) put_b(8'hF6);
    nwr = 0;
    pulse_start();
    send_img(0, -1);
    @(negedge clk);
    check("n2 core_reset e0", 32'(core_reset), 32'd1);
    tick(); @(negedge clk);
    check("n2 core_reset e1", 32'(core_reset), 32'd1);
    tick(); @(negedge clk);
    check("n2 core_reset e2", 32'(core_reset), 32'd0);
    check("n2 done",          32'(done),       32'd1);
    check("n2 writes",        32'(nwr),        32'd2);
    check("n2 word0",         dmem[0],         32'h00000013);
    check("n2 word1",         dmem[1],         32'h00500093);
    check("n2 last addr",     32'(last_addr),  32'd1);

    // N = 0, then stray bytes while not ready
    img.delete(); put_w(32'd0);
    nwr = 0;
    pulse_start();
    send_img(0, -1);
    tick(); @(negedge clk);
    check("n0 error",      32'(error),        32'd1);
    check("n0 core_reset", 32'(core_reset),   32'd1);
    check("n0 rx_ready",   32'(bus.rx_ready), 32'd0);
    check("n0 done",       32'(done),         32'd0);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    repeat (3) tick();
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("n0 writes",     32'(nwr),   32'd0);
    check("n0 error held", 32'(error), 32'd1);

    // Length bounds
    img.delete(); put_w(32'd65);
    pulse_start(); send_img(0, -1); tick(); @(negedge clk);
    check("n65 error", 32'(error), 32'd1);
    img.delete(); put_w(32'h00010001);
    pulse_start(); send_img(0, -1); tick(); @(negedge clk);
    check("n10001 error", 32'(error), 32'd1);
    img.delete(); put_w(32'd64);
    for (int i = 0; i < 64; i++) put_w(wpat(i));
    if (CHK) put_b(img_sum());
    nwr = 0;
    pulse_start(); send_img(0, -1);
    repeat (2) tick(); @(negedge clk);
    check("n64 done",      32'(done),      32'd1);
    check("n64 writes",    32'(nwr),       32'd64);
    check("n64 last addr", 32'(last_addr), 32'd63);
    check("n64 word63",    dmem[63],       wpat(63));

`ifdef BOOT_CHECKSUM_EN
    img.delete(); put_w(32'd1); put_w(32'h11223344); put_b(8'hAA);
    pulse_start(); send_img(0, -1); repeat (2) tick(); @(negedge clk);
    check("chk ok done",  32'(done),  32'd1);
    check("chk ok error", 32'(error), 32'd0);
    img.delete(); put_w(32'd1); put_w(32'h11223344); put_b(8'hAB);
    pulse_start(); send_img(0, -1); repeat (2) tick(); @(negedge clk);
    check("chk bad error",      32'(error),      32'd1);
    check("chk bad done",       32'(done),       32'd0);
    check("chk bad core_reset", 32'(core_reset), 32'd1);
`endif

    // Gap-free reference run, then gapped run with a start pulse mid-LOAD
    img.delete(); put_w(32'd8);
    for (int i = 0; i < 8; i++) begin
      ref_words[i] = $urandom;
      put_w(ref_words[i]);
    end
    if (CHK) put_b(img_sum());
    for (int i = 0; i < 8; i++) dmem[i] = 32'h0;
    pulse_start(); send_img(0, -1); repeat (2) tick(); @(negedge clk);
    check("gapfree done", 32'(done), 32'd1);
    for (int i = 0; i < 8; i++) copy_words[i] = dmem[i];
    for (int i = 0; i < 8; i++) dmem[i] = 32'h0;
    nwr = 0;
    pulse_start(); send_img(3, 10); repeat (2) tick(); @(negedge clk);
    check("gapped done",   32'(done), 32'd1);
    check("gapped writes", 32'(nwr),  32'd8);
    for (int i = 0; i < 8; i++) check("gapped word", dmem[i], copy_words[i]);
    check("gapped word0 vs image", dmem[0], ref_words[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
